ddr3_cmd_seq: RTL and testbench

DDR3_CMD_SEQ -- requirements
Module: ddr3_cmd_seq

---
 rtl/ddr3_ctrl_pkg.sv | 55 +++++
 rtl/ddr3_refresh_timer.sv | 43 ++++
 rtl/ddr3_cmd_seq.sv | 196 +++++++++++++++++++
 tb/tb_ddr3_cmd_seq.sv | 283 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ddr3_ctrl_pkg.sv
// Shared definitions for the DDR3 command sequencer: command encodings,
// sequencer states, address field widths and the mode-register table.
package ddr3_ctrl_pkg;

  localparam int ROW_W  = 14;
  localparam int BANK_W = 3;
  localparam int COL_W  = 10;
  localparam int ADDR_W = ROW_W + BANK_W + COL_W;
  localparam int AP_BIT = 10;

  // {cs_n, ras_n, cas_n, we_n}
  localparam logic [3:0] CMD_NOP = 4'b0111;
  localparam logic [3:0] CMD_ACT = 4'b0011;
  localparam logic [3:0] CMD_RD  = 4'b0101;
  localparam logic [3:0] CMD_WR  = 4'b0100;
  localparam logic [3:0] CMD_REF = 4'b0001;
  localparam logic [3:0] CMD_MRS = 4'b0000;

  typedef enum logic [2:0] {
    CKE_WAIT,
    MRS,
    IDLE,
    ACT,
    RW,
    RW_WAIT,
    REF_WAIT
  } state_e;

  // Mode register values, indexed by MR number
  function automatic logic [ROW_W-1:0] mrValue(input logic [1:0] mr);
    case (mr)
      2'd0:    return 14'h0520;
      2'd1:    return 14'h0044;
      2'd2:    return 14'h0008;
      default: return 14'h0000;
    endcase
  endfunction

  // Initialisation writes the mode registers in the order MR2, MR3, MR1, MR0
  function automatic logic [BANK_W-1:0] mrsBank(input logic [1:0] step);
    case (step)
      2'd0:    return 3'd2;
      2'd1:    return 3'd3;
      2'd2:    return 3'd1;
      default: return 3'd0;
    endcase
  endfunction

  function automatic logic [ROW_W-1:0] mrsAddr(input logic [1:0] step);
    logic [BANK_W-1:0] mr;
    mr = mrsBank(step);
    return mrValue(mr[1:0]);
  endfunction

endpackage

// File: rtl/ddr3_refresh_timer.sv
// Refresh interval timer: raises pending every TREFI clocks while enabled;
// a further expiry while pending is still set does not stack a second request.
module ddr3_refresh_timer #(
  parameter int TREFI = 3120
) (
  input  logic clk,
  input  logic rst,
  input  logic enable,
  input  logic ack,
  output logic pending
);

  localparam int TW = $clog2(TREFI + 1);

  logic [TW-1:0] cnt_q, cnt_d;
  logic          pending_q, pending_d;

  always_comb begin
    cnt_d     = cnt_q;
    pending_d = pending_q & ~ack;
    if (enable) begin
      if (cnt_q == TW'(TREFI - 1)) begin
        cnt_d     = '0;
        pending_d = 1'b1;
      end else begin
        cnt_d = cnt_q + TW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q     <= '0;
      pending_q <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      pending_q <= pending_d;
    end
  end

  assign pending = pending_q;

endmodule

// File: rtl/ddr3_cmd_seq.sv
// DDR3 command sequencer: power-up/mode-register initialisation, single
// closed-page read/write per request with auto-precharge, and periodic refresh.
module ddr3_cmd_seq
  import ddr3_ctrl_pkg::*;
#(
  parameter int INIT_CYCLES = 200,
  parameter int TMRD        = 4,
  parameter int TRCD        = 6,
  parameter int TRC         = 20,
  parameter int TRFC        = 64,
  parameter int TREFI       = 3120
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [ADDR_W-1:0] req_addr,
  output logic              init_done,
  output logic              rd_issue,
  output logic              wr_issue,
  output logic              ddr3_cke,
  output logic              ddr3_cs_n,
  output logic              ddr3_ras_n,
  output logic              ddr3_cas_n,
  output logic              ddr3_we_n,
  output logic [BANK_W-1:0] ddr3_ba,
  output logic [ROW_W-1:0]  ddr3_addr
);

  localparam int M1 = (INIT_CYCLES > TREFI) ? INIT_CYCLES : TREFI;
  localparam int M2 = (M1 > TRFC) ? M1 : TRFC;
  localparam int M3 = (M2 > TRC) ? M2 : TRC;
  localparam int CW = $clog2(M3 + 1);

  if (TRC < TRCD + 2) begin : gTrcCheck
    $fatal(1, "ddr3_cmd_seq: TRC must be at least TRCD+2");
  end
  if (TRCD < 2 || TRFC < 2) begin : gMinCheck
    $fatal(1, "ddr3_cmd_seq: TRCD and TRFC must be at least 2");
  end

  state_e            state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [1:0]        mrStep_q, mrStep_d;
  logic              initDone_q, initDone_d;
  logic              cke_q, cke_d;
  logic [3:0]        cmd_q, cmd_d;
  logic [BANK_W-1:0] ba_q, ba_d;
  logic [ROW_W-1:0]  addr_q, addr_d;
  logic              rdIssue_q, rdIssue_d;
  logic              wrIssue_q, wrIssue_d;
  logic              reqWe_q, reqWe_d;
  logic [BANK_W-1:0] reqBank_q, reqBank_d;
  logic [COL_W-1:0]  reqCol_q, reqCol_d;
  logic              refPending;
  logic              refAck;

  ddr3_refresh_timer #(.TREFI(TREFI)) uRefTimer (
    .clk     (clk),
    .rst     (rst),
    .enable  (initDone_q),
    .ack     (refAck),
    .pending (refPending)
  );

  assign req_ready = (state_q == IDLE) && initDone_q && !refPending;

  // cnt_q counts cycles since the last command that opened a timed window
  // (ACT or REF), so RW_WAIT/REF_WAIT leave one cycle early for the
  // registered command outputs to land exactly on TRC/TRFC.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    mrStep_d   = mrStep_q;
    initDone_d = initDone_q;
    cke_d      = cke_q;
    cmd_d      = CMD_NOP;
    ba_d       = '0;
    addr_d     = '0;
    rdIssue_d  = 1'b0;
    wrIssue_d  = 1'b0;
    reqWe_d    = reqWe_q;
    reqBank_d  = reqBank_q;
    reqCol_d   = reqCol_q;
    refAck     = 1'b0;
    case (state_q)
      CKE_WAIT: begin
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == CW'(INIT_CYCLES - 1)) begin
          cke_d    = 1'b1;
          cnt_d    = '0;
          mrStep_d = '0;
          state_d  = MRS;
        end
      end
      MRS: begin
        if (cnt_q == '0) begin
          cmd_d  = CMD_MRS;
          ba_d   = mrsBank(mrStep_q);
          addr_d = mrsAddr(mrStep_q);
        end
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == CW'(TMRD - 1)) begin
          cnt_d = '0;
          if (mrStep_q == 2'd3) begin
            initDone_d = 1'b1;
            state_d    = IDLE;
          end else begin
            mrStep_d = mrStep_q + 2'd1;
          end
        end
      end
      IDLE: begin
        cnt_d = '0;
        if (refPending) begin
          cmd_d   = CMD_REF;
          refAck  = 1'b1;
          state_d = REF_WAIT;
        end else if (req_valid && req_ready) begin
          cmd_d     = CMD_ACT;
          ba_d      = req_addr[COL_W +: BANK_W];
          addr_d    = req_addr[COL_W + BANK_W +: ROW_W];
          reqWe_d   = req_we;
          reqBank_d = req_addr[COL_W +: BANK_W];
          reqCol_d  = req_addr[COL_W-1:0];
          state_d   = ACT;
        end
      end
      ACT: begin
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == CW'(TRCD - 2)) state_d = RW;
      end
      RW: begin
        cmd_d               = reqWe_q ? CMD_WR : CMD_RD;
        ba_d                = reqBank_q;
        addr_d[COL_W-1:0]   = reqCol_q;
        addr_d[AP_BIT]      = 1'b1;
        rdIssue_d           = !reqWe_q;
        wrIssue_d           = reqWe_q;
        cnt_d               = cnt_q + CW'(1);
        state_d             = RW_WAIT;
      end
      RW_WAIT: begin
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == CW'(TRC - 2)) state_d = IDLE;
      end
      REF_WAIT: begin
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == CW'(TRFC - 2)) state_d = IDLE;
      end
      default: state_d = CKE_WAIT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= CKE_WAIT;
      cnt_q      <= '0;
      mrStep_q   <= '0;
      initDone_q <= 1'b0;
      cke_q      <= 1'b0;
      cmd_q      <= CMD_NOP;
      ba_q       <= '0;
      addr_q     <= '0;
      rdIssue_q  <= 1'b0;
      wrIssue_q  <= 1'b0;
      reqWe_q    <= 1'b0;
      reqBank_q  <= '0;
      reqCol_q   <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      mrStep_q   <= mrStep_d;
      initDone_q <= initDone_d;
      cke_q      <= cke_d;
      cmd_q      <= cmd_d;
      ba_q       <= ba_d;
      addr_q     <= addr_d;
      rdIssue_q  <= rdIssue_d;
      wrIssue_q  <= wrIssue_d;
      reqWe_q    <= reqWe_d;
      reqBank_q  <= reqBank_d;
      reqCol_q   <= reqCol_d;
    end
  end

  assign {ddr3_cs_n, ddr3_ras_n, ddr3_cas_n, ddr3_we_n} = cmd_q;
  assign ddr3_cke  = cke_q;
  assign ddr3_ba   = ba_q;
  assign ddr3_addr = addr_q;
  assign init_done = initDone_q;
  assign rd_issue  = rdIssue_q;
  assign wr_issue  = wrIssue_q;

endmodule

// File: tb/tb_ddr3_cmd_seq.sv
// Directed bench for ddr3_cmd_seq: initialisation, read, back-to-back writes,
// refresh priority and deferral, and reset in the middle of a request.
module tb_ddr3_cmd_seq;

  localparam logic [3:0] NOP_C = 4'b0111;
  localparam logic [3:0] ACT_C = 4'b0011;
  localparam logic [3:0] RD_C  = 4'b0101;
  localparam logic [3:0] WR_C  = 4'b0100;
  localparam logic [3:0] REF_C = 4'b0001;
  localparam logic [3:0] MRS_C = 4'b0000;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [26:0] req_addr;
  logic        init_done;
  logic        rd_issue;
  logic        wr_issue;
  logic        ddr3_cke;
  logic        ddr3_cs_n;
  logic        ddr3_ras_n;
  logic        ddr3_cas_n;
  logic        ddr3_we_n;
  logic [2:0]  ddr3_ba;
  logic [13:0] ddr3_addr;
  logic [3:0]  cmdNow;

  typedef struct {
    int         cyc;
    logic [3:0] cmd;
    logic [2:0] ba;
    logic [13:0] addr;
  } cmdRec_t;

  cmdRec_t cmdLog[$];
  int cyc = 0;
  int rel = 0;
  int checks = 0;
  int errors = 0;
  int rdCnt = 0;
  int wrCnt = 0;
  int pulseErr = 0;

  logic [2:0]  expBa[4] = '{3'd2, 3'd3, 3'd1, 3'd0};
  logic [13:0] expMr[4] = '{14'h0008, 14'h0000, 14'h0044, 14'h0520};

  ddr3_cmd_seq dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_we     (req_we),
    .req_addr   (req_addr),
    .init_done  (init_done),
    .rd_issue   (rd_issue),
    .wr_issue   (wr_issue),
    .ddr3_cke   (ddr3_cke),
    .ddr3_cs_n  (ddr3_cs_n),
    .ddr3_ras_n (ddr3_ras_n),
    .ddr3_cas_n (ddr3_cas_n),
    .ddr3_we_n  (ddr3_we_n),
    .ddr3_ba    (ddr3_ba),
    .ddr3_addr  (ddr3_addr)
  );

  assign cmdNow = {ddr3_cs_n, ddr3_ras_n, ddr3_cas_n, ddr3_we_n};

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Record every non-NOP command with the clock on which it was driven
  always @(negedge clk) begin
    if (cmdNow != NOP_C) cmdLog.push_back('{cyc, cmdNow, ddr3_ba, ddr3_addr});
    if (rd_issue) rdCnt++;
    if (wr_issue) wrCnt++;
    if ((rd_issue && cmdNow != RD_C) || (wr_issue && cmdNow != WR_C)) pulseErr++;
  end

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("[TB] FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input logic v, input logic we, input logic [26:0] a);
    req_valid = v;
    req_we    = we;
    req_addr  = a;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic stepTo(input int k);
    while (cyc < rel + k) tick();
  endtask

  task automatic checkInit();
    stepTo(199);
    checkOutput("cke low @199", 32'(ddr3_cke), 32'd0);
    stepTo(200);
    checkOutput("cke high @200", 32'(ddr3_cke), 32'd1);
    stepTo(215);
    checkOutput("init_done @215", 32'(init_done), 32'd0);
    checkOutput("ready @215", 32'(req_ready), 32'd0);
    stepTo(216);
    checkOutput("init_done @216", 32'(init_done), 32'd1);
    checkOutput("ready @216", 32'(req_ready), 32'd1);
    checkOutput("mrs count", 32'(cmdLog.size()), 32'd4);
    for (int i = 0; i < 4 && i < cmdLog.size(); i++) begin
      checkOutput($sformatf("mrs%0d clock", i), 32'(cmdLog[i].cyc - rel), 32'(201 + 4 * i));
      checkOutput($sformatf("mrs%0d cmd", i), 32'(cmdLog[i].cmd), 32'(MRS_C));
      checkOutput($sformatf("mrs%0d ba", i), 32'(cmdLog[i].ba), 32'(expBa[i]));
      checkOutput($sformatf("mrs%0d addr", i), 32'(cmdLog[i].addr), 32'(expMr[i]));
    end
  endtask

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish, errors=%0d", errors);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int t0;
    int accepts;
    int guard;
    logic [26:0] wrAddr;
    logic [26:0] rdAddr2;
    logic [26:0] rdAddr3;
    wrAddr  = {14'h1ABC, 3'd5, 10'h2F3};
    rdAddr2 = {14'h0123, 3'd7, 10'h3FF};
    rdAddr3 = {14'h3FFF, 3'd0, 10'h000};

    rst = 1'b1;
    applyStimulus(1'b0, 1'b0, 27'h0);
    repeat (3) tick();
    checkOutput("reset cke", 32'(ddr3_cke), 32'd0);
    checkOutput("reset init_done", 32'(init_done), 32'd0);
    checkOutput("reset ready", 32'(req_ready), 32'd0);
    checkOutput("reset cmd", 32'(cmdNow), 32'(NOP_C));
    checkOutput("reset ba/addr", 32'({ddr3_ba, ddr3_addr}), 32'd0);
    checkOutput("reset issue", 32'({rd_issue, wr_issue}), 32'd0);
    rst = 1'b0;
    rel = cyc;
    cmdLog.delete();
    checkInit();

    // Single read; the row field of 0x1234567 is addr[26:13] = 0x091A
    cmdLog.delete();
    rdCnt = 0;
    wrCnt = 0;
    applyStimulus(1'b1, 1'b0, 27'h1234567);
    tick();
    t0 = cyc;
    applyStimulus(1'b0, 1'b0, 27'h0);
    checkOutput("ready low on ACT", 32'(req_ready), 32'd0);
    while (cyc < t0 + 18) tick();
    checkOutput("ready @T+18", 32'(req_ready), 32'd0);
    tick();
    checkOutput("ready @T+19", 32'(req_ready), 32'd1);
    checkOutput("read cmd count", 32'(cmdLog.size()), 32'd2);
    if (cmdLog.size() >= 2) begin
      checkOutput("read ACT clock", 32'(cmdLog[0].cyc), 32'(t0));
      checkOutput("read ACT cmd", 32'(cmdLog[0].cmd), 32'(ACT_C));
      checkOutput("read ACT ba", 32'(cmdLog[0].ba), 32'd1);
      checkOutput("read ACT addr", 32'(cmdLog[0].addr), 32'h091A);
      checkOutput("read RD clock", 32'(cmdLog[1].cyc), 32'(t0 + 6));
      checkOutput("read RD cmd", 32'(cmdLog[1].cmd), 32'(RD_C));
      checkOutput("read RD ba", 32'(cmdLog[1].ba), 32'd1);
      checkOutput("read RD addr", 32'(cmdLog[1].addr), 32'h0567);
    end
    checkOutput("read rd_issue count", 32'(rdCnt), 32'd1);
    checkOutput("read wr_issue count", 32'(wrCnt), 32'd0);

    // Three writes with req_valid held high
    cmdLog.delete();
    wrCnt = 0;
    applyStimulus(1'b1, 1'b1, wrAddr);
    accepts = 0;
    guard = 0;
    while (accepts < 3 && guard < 200) begin
      if (req_ready) accepts++;
      tick();
      guard++;
    end
    applyStimulus(1'b0, 1'b0, 27'h0);
    checkOutput("write accepts", 32'(accepts), 32'd3);
    repeat (25) tick();
    checkOutput("write cmd count", 32'(cmdLog.size()), 32'd6);
    for (int i = 0; i < 3 && 2 * i + 1 < cmdLog.size(); i++) begin
      checkOutput($sformatf("wr%0d ACT cmd", i), 32'(cmdLog[2*i].cmd), 32'(ACT_C));
      checkOutput($sformatf("wr%0d ACT spacing", i), 32'(cmdLog[2*i].cyc - cmdLog[0].cyc), 32'(20 * i));
      checkOutput($sformatf("wr%0d ACT addr", i), 32'({cmdLog[2*i].ba, cmdLog[2*i].addr}), 32'({3'd5, 14'h1ABC}));
      checkOutput($sformatf("wr%0d WR cmd", i), 32'(cmdLog[2*i+1].cmd), 32'(WR_C));
      checkOutput($sformatf("wr%0d WR delay", i), 32'(cmdLog[2*i+1].cyc - cmdLog[2*i].cyc), 32'd6);
      checkOutput($sformatf("wr%0d WR addr", i), 32'({cmdLog[2*i+1].ba, cmdLog[2*i+1].addr}), 32'({3'd5, 14'h06F3}));
    end
    checkOutput("write wr_issue count", 32'(wrCnt), 32'd3);

    // Refresh becomes pending at clock 216 + 3120 = 3336, the same cycle valid rises
    stepTo(3335);
    checkOutput("ready before refresh", 32'(req_ready), 32'd1);
    cmdLog.delete();
    tick();
    checkOutput("ready with refresh pending", 32'(req_ready), 32'd0);
    applyStimulus(1'b1, 1'b0, rdAddr2);
    guard = 0;
    while (!req_ready && guard < 200) begin
      tick();
      guard++;
    end
    tick();
    applyStimulus(1'b0, 1'b0, 27'h0);
    stepTo(3425);
    checkOutput("refprio cmd count", 32'(cmdLog.size()), 32'd3);
    if (cmdLog.size() >= 3) begin
      checkOutput("refprio REF first", 32'(cmdLog[0].cmd), 32'(REF_C));
      checkOutput("refprio REF clock", 32'(cmdLog[0].cyc - rel), 32'd3337);
      checkOutput("refprio ACT cmd", 32'(cmdLog[1].cmd), 32'(ACT_C));
      checkOutput("refprio ACT after TRFC", 32'(cmdLog[1].cyc - cmdLog[0].cyc), 32'd64);
      checkOutput("refprio RD addr", 32'({cmdLog[2].cmd, cmdLog[2].ba, cmdLog[2].addr}), 32'({RD_C, 3'd7, 14'h07FF}));
    end

    // Next refresh is due at 3336 + 3120 = 6456, while this read is in flight
    stepTo(6449);
    checkOutput("ready before inflight read", 32'(req_ready), 32'd1);
    cmdLog.delete();
    rdCnt = 0;
    applyStimulus(1'b1, 1'b0, rdAddr3);
    tick();
    applyStimulus(1'b0, 1'b0, 27'h0);
    stepTo(6475);
    checkOutput("inflight cmd count", 32'(cmdLog.size()), 32'd3);
    if (cmdLog.size() >= 3) begin
      checkOutput("inflight ACT", 32'({cmdLog[0].cmd, cmdLog[0].ba, cmdLog[0].addr}), 32'({ACT_C, 3'd0, 14'h3FFF}));
      checkOutput("inflight ACT clock", 32'(cmdLog[0].cyc - rel), 32'd6450);
      checkOutput("inflight RD", 32'({cmdLog[1].cmd, cmdLog[1].ba, cmdLog[1].addr}), 32'({RD_C, 3'd0, 14'h0400}));
      checkOutput("inflight RD clock", 32'(cmdLog[1].cyc - rel), 32'd6456);
      checkOutput("inflight REF cmd", 32'(cmdLog[2].cmd), 32'(REF_C));
      checkOutput("inflight REF clock", 32'(cmdLog[2].cyc - rel), 32'd6470);
    end
    checkOutput("inflight rd_issue count", 32'(rdCnt), 32'd1);

    // Reset 3 clocks after ACT aborts the write and restarts initialisation
    stepTo(6533);
    checkOutput("ready before abort", 32'(req_ready), 32'd1);
    rdCnt = 0;
    wrCnt = 0;
    applyStimulus(1'b1, 1'b1, wrAddr);
    tick();
    t0 = cyc;
    applyStimulus(1'b0, 1'b0, 27'h0);
    checkOutput("abort ACT driven", 32'(cmdNow), 32'(ACT_C));
    tick();
    tick();
    rst = 1'b1;
    tick();
    checkOutput("abort clock", 32'(cyc - t0), 32'd3);
    checkOutput("abort cmd NOP", 32'(cmdNow), 32'(NOP_C));
    checkOutput("abort cke", 32'(ddr3_cke), 32'd0);
    checkOutput("abort init_done", 32'(init_done), 32'd0);
    checkOutput("abort ready", 32'(req_ready), 32'd0);
    rst = 1'b0;
    rel = cyc;
    cmdLog.delete();
    checkInit();
    checkOutput("abort wr_issue count", 32'(wrCnt), 32'd0);
    checkOutput("abort rd_issue count", 32'(rdCnt), 32'd0);
    checkOutput("issue pulse alignment", 32'(pulseErr), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
